// File: rtl/dpfifo_pkg.sv
// Shared definitions for the dpfifo slice: default geometry and a log2 helper.
package dpfifo_pkg;

    localparam int DEF_WR_W  = 8;
    localparam int DEF_RATIO = 2;
    localparam int DEF_AW    = 6;

    // Ceiling log2; used to turn RATIO into a shift amount (log2c(1) = 0).
    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dpfifo_dpram.sv
// Asymmetric dual-port RAM: narrow write port, RATIO-times-wider registered read port.
module dpram_p
    import dpfifo_pkg::*;
#(
    parameter int WR_W  = DEF_WR_W,
    parameter int RATIO = DEF_RATIO,
    parameter int AW    = DEF_AW,
    localparam int LR   = log2c(RATIO),
    localparam int WA   = AW - LR
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [WR_W-1:0]         wdata,
    input  logic                    re,
    input  logic [WA-1:0]           raddr,
    output logic [WR_W*RATIO-1:0]   rdata
);

    logic [WR_W-1:0] mem [0:(2**AW)-1];
    logic [AW-1:0]   rbase;

    // Unit 0 of a word sits at the lowest unit address of that word.
    assign rbase = AW'(raddr) << LR;

    // Write port; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port: gather RATIO consecutive units, first-written in the low bits; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            for (int k = 0; k < RATIO; k++) begin
                rdata[k*WR_W +: WR_W] <= mem[rbase + AW'(k)];
            end
        end
    end

endmodule

// File: rtl/dpfifo.sv
// Width-converting FIFO: WR_W-bit writes, WR_W*RATIO-bit reads, registered flags and level.
module dpfifo
    import dpfifo_pkg::*;
#(
    parameter int WR_W  = DEF_WR_W,
    parameter int RATIO = DEF_RATIO,
    parameter int AW    = DEF_AW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [WR_W-1:0]         wr_data,
    output logic                    full,
    input  logic                    rd_en,
    output logic [WR_W*RATIO-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    empty,
    output logic [AW:0]             level,
    output logic                    ovf,
    output logic                    udf
);

    localparam int LR = log2c(RATIO);
    localparam int WA = AW - LR;
    localparam logic [AW:0] CAP  = (AW+1)'(2**AW);
    localparam logic [AW:0] WORD = (AW+1)'(RATIO);

    // Pointers carry one wrap bit above the address bits.
    logic [AW:0] wr_ptr, wr_ptr_n;
    logic [WA:0] rd_ptr, rd_ptr_n;
    logic [AW:0] level_n;
    logic        wr_acc, rd_acc;

    // Acceptance and next pointer/level; flush wins over both strobes.
    always_comb begin
        wr_acc   = wr_en && !full  && !flush;
        rd_acc   = rd_en && !empty && !flush;
        wr_ptr_n = wr_ptr + (AW+1)'(wr_acc);
        rd_ptr_n = rd_ptr + (WA+1)'(rd_acc);
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end
        level_n = wr_ptr_n - ((AW+1)'(rd_ptr_n) << LR);
    end

    // Pointer, flag, level and sticky-error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            level    <= level_n;
            full     <= (level_n == CAP);
            empty    <= (level_n < WORD);
            rd_valid <= rd_acc;
            ovf      <= flush ? 1'b0 : (ovf | (wr_en & full));
            udf      <= flush ? 1'b0 : (udf | (rd_en & empty));
        end
    end

    dpram_p #(
        .WR_W  (WR_W),
        .RATIO (RATIO),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr[WA-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_dpfifo.sv
// Bench for dpfifo at default geometry: byte-queue model, word scoreboard, directed sequences.
module tb_dpfifo;

    localparam int WR_W  = 8;
    localparam int RATIO = 2;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    // Handshake: a write is taken on a rising edge when wr_en=1 and full=0; a read
    // is taken when rd_en=1 and empty=0, and its word appears with rd_valid=1 after that edge.

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              wr_en = 1'b0;
    logic [WR_W-1:0]   wr_data = '0;
    logic              full;
    logic              rd_en = 1'b0;
    logic [15:0]       rd_data;
    logic              rd_valid;
    logic              empty;
    logic [AW:0]       level;
    logic              ovf;
    logic              udf;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  model_q[$];
    logic [15:0] exp_q[$];

    dpfifo #(.WR_W(WR_W), .RATIO(RATIO), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .level    (level),
        .ovf      (ovf),
        .udf      (udf)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; model decisions use the occupancy before the edge.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r);
        int cnt;
        logic [7:0] b0, b1;
        cnt = model_q.size();
        wr_en = w;
        wr_data = d;
        rd_en = r;
        if (r && cnt >= RATIO) begin
            b0 = model_q.pop_front();
            b1 = model_q.pop_front();
            exp_q.push_back({b1, b0});
        end
        if (w && cnt < DEPTH) model_q.push_back(d);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        model_q.delete();
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Monitor: every presented word is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL rd_unexpected: got %h with nothing expected", rd_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_errors++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, e);
                end
            end
        end
    end

    initial begin
        int maxlvl;
        // Reset values while held in reset
        repeat (3) tick();
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_ovf", ovf, 0);
        check("rst_udf", udf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Three writes, then a single read
        cycle(1, 8'h05, 0);
        check("w1_level", level, 1);
        check("w1_empty", empty, 1);
        cycle(1, 8'h06, 0);
        check("w2_level", level, 2);
        check("w2_empty", empty, 0);
        cycle(1, 8'h07, 0);
        check("w3_level", level, 3);
        cycle(0, 8'h00, 1);
        check("r1_valid", rd_valid, 1);
        check("r1_data", rd_data, 16'h0605);
        check("r1_level", level, 1);
        check("r1_empty", empty, 1);
        tick();
        check("idle_valid", rd_valid, 0);
        check("idle_hold", rd_data, 16'h0605);

        // Underflow is dropped and sticky, flush clears it
        cycle(0, 8'h00, 1);
        check("udf_valid", rd_valid, 0);
        check("udf_set", udf, 1);
        check("udf_level", level, 1);
        tick();
        check("udf_sticky", udf, 1);
        do_flush();
        check("flush_udf", udf, 0);
        check("flush_level", level, 0);
        check("flush_empty", empty, 1);
        check("flush_valid", rd_valid, 0);

        // Fill to capacity, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 8'(i), 0);
            if (i == DEPTH - 2) check("fill63_full", full, 0);
        end
        check("fill_full", full, 1);
        check("fill_level", level, DEPTH);
        cycle(1, 8'hAA, 0);
        check("ovf_set", ovf, 1);
        check("ovf_level", level, DEPTH);

        // Read while full is accepted while a concurrent write is rejected
        cycle(1, 8'hBB, 1);
        check("rfull_level", level, DEPTH - 2);
        check("rfull_full", full, 0);
        for (int i = 1; i < DEPTH / RATIO; i++) cycle(0, 8'h00, 1);
        tick();
        check("drain_level", level, 0);
        check("drain_empty", empty, 1);
        check("ovf_sticky", ovf, 1);
        do_flush();
        check("flush_ovf", ovf, 0);

        // Streaming with simultaneous read/write across several pointer wraps
        for (int i = 0; i < 6; i++) cycle(1, 8'(8'hC0 + i), 0);
        maxlvl = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(1, 8'(i * 13 + 5), (i % 2) == 1);
            if (int'(level) > maxlvl) maxlvl = int'(level);
            if (i % 50 == 49) check("stream_level", level, model_q.size());
        end
        check("stream_max_le_64", (maxlvl <= DEPTH) ? 1 : 0, 1);
        check("stream_udf", udf, 0);
        check("stream_ovf", ovf, 0);
        while (model_q.size() >= RATIO) cycle(0, 8'h00, 1);
        tick();
        check("stream_drain_level", level, model_q.size());
        check("stream_sb_empty", exp_q.size(), 0);

        // Reset right after an accepted read aborts the pending word
        do_flush();
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h50 + i), 0);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rd_en = 1'b0;
        exp_q.delete();
        model_q.delete();
        #1;
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_data", rd_data, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_full", full, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_hold_valid", rd_valid, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", rd_valid, 0);
        check("post_rst_level", level, 0);

        tick();
        tick();
        check("final_sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
